// File: rtl/inst_fetch_unit.sv
// Instruction fetch initiator.
// Owns the fetch PC and drives InstMem's address, which is read combinationally.
// Returned instructions are queued with their PCs in a small FIFO for decode.
// A redirect flushes the queue and restarts fetch at the new PC.
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] ADDR_INC = 32'd4,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_en,
  output logic [31:0] InstAddress,
  input  logic [31:0] Inst,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_inst,
  output logic [31:0] dec_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned   PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned   CW   = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   inst_mem_q [DEPTH];
  logic [31:0]   pc_mem_q   [DEPTH];
  logic          push, pop;

  // Handshake decode and next-state; redirect suppresses both push and pop
  always_comb begin
    pop        = (count_q != '0) & dec_ready & ~redirect_valid;
    push       = fetch_en & ~redirect_valid & ((count_q < FULL) | pop);
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + ADDR_INC;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      inst_mem_q[wr_ptr_q] <= Inst;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

  // Head outputs, forced to zero when the queue is empty
  always_comb begin
    InstAddress = fetch_pc_q;
    dec_valid   = (count_q != '0);
    dec_inst    = dec_valid ? inst_mem_q[rd_ptr_q] : '0;
    dec_pc      = dec_valid ? pc_mem_q[rd_ptr_q]   : '0;
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: one cycle-by-cycle vector table for the
// default instance, plus a hand-written wrap sequence for a high RESET_PC instance.
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, fetch_en, dec_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] addr0, inst0, dinst0, dpc0;
  logic [31:0] addr1, inst1, dinst1, dpc1;
  logic        dv0, dv1;

  int unsigned n_vec  = 0;
  int unsigned n_fail = 0;

  always #5 clk = ~clk;

  // InstMem model: word i holds 32'h1000 + i
  function automatic logic [31:0] memword(input logic [31:0] a);
    return 32'h0000_1000 + (a >> 2);
  endfunction

  assign inst0 = memword(addr0);
  assign inst1 = memword(addr1);

  inst_fetch_unit dut0 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .InstAddress(addr0), .Inst(inst0),
    .dec_valid(dv0), .dec_ready(dec_ready), .dec_inst(dinst0), .dec_pc(dpc0),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .InstAddress(addr1), .Inst(inst1),
    .dec_valid(dv1), .dec_ready(dec_ready), .dec_inst(dinst1), .dec_pc(dpc1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    logic        rst, fe, rdy, redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc, eaddr;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic fe, input logic rdy, input logic rd,
                              input logic [31:0] rpc, input logic ev,
                              input logic [31:0] epc, input logic [31:0] eaddr);
    vec_t v;
    v.rst = r; v.fe = fe; v.rdy = rdy; v.redir = rd; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.eaddr = eaddr;
    return v;
  endfunction

  task automatic check(input string name, input int unsigned idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %h expected %h", name, idx, got, exp);
    end
  endtask

  // Compares one instance's outputs for a cycle; instruction follows from the PC
  task automatic check_out(input string tag, input int unsigned idx, input logic ev,
                           input logic [31:0] epc, input logic [31:0] eaddr,
                           input logic gv, input logic [31:0] gpc,
                           input logic [31:0] ginst, input logic [31:0] gaddr);
    check({tag, ".dec_valid"}, idx, {31'd0, gv}, {31'd0, ev});
    check({tag, ".InstAddress"}, idx, gaddr, eaddr);
    check({tag, ".dec_pc"}, idx, gpc, ev ? epc : 32'h0);
    check({tag, ".dec_inst"}, idx, ginst, ev ? memword(epc) : 32'h0);
  endtask

  task automatic drive(input logic r, input logic fe, input logic rdy, input logic rd,
                       input logic [31:0] rpc);
    rst = r; fetch_en = fe; dec_ready = rdy; redirect_valid = rd; redirect_pc = rpc;
  endtask

  vec_t tbl [30];

  initial begin
    //              rst fe rdy rd  rpc     ev  epc     eaddr
    tbl[0]  = mk(1, 1, 1, 0, 32'h0,  0, 32'h00, 32'h00);  // held in reset, no push
    tbl[1]  = mk(0, 1, 1, 0, 32'h0,  0, 32'h00, 32'h00);  // first fetch
    tbl[2]  = mk(0, 1, 1, 0, 32'h0,  1, 32'h00, 32'h04);  // 1-cycle latency
    tbl[3]  = mk(0, 1, 1, 0, 32'h0,  1, 32'h04, 32'h08);
    tbl[4]  = mk(0, 1, 1, 0, 32'h0,  1, 32'h08, 32'h0C);
    tbl[5]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h10);  // back-pressure begins
    tbl[6]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h14);
    tbl[7]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h18);
    tbl[8]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h1C);  // full: PC stalls
    tbl[9]  = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h1C);
    tbl[10] = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h1C);
    tbl[11] = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h1C);
    tbl[12] = mk(0, 1, 0, 0, 32'h0,  1, 32'h0C, 32'h1C);
    tbl[13] = mk(0, 1, 1, 0, 32'h0,  1, 32'h0C, 32'h1C);  // full with push+pop
    tbl[14] = mk(0, 1, 1, 0, 32'h0,  1, 32'h10, 32'h20);
    tbl[15] = mk(0, 1, 1, 0, 32'h0,  1, 32'h14, 32'h24);
    tbl[16] = mk(0, 1, 1, 1, 32'h40, 1, 32'h18, 32'h28);  // redirect, head dropped
    tbl[17] = mk(0, 1, 1, 0, 32'h0,  0, 32'h00, 32'h40);
    tbl[18] = mk(0, 1, 1, 0, 32'h0,  1, 32'h40, 32'h44);
    tbl[19] = mk(0, 1, 1, 0, 32'h0,  1, 32'h44, 32'h48);
    tbl[20] = mk(0, 0, 1, 0, 32'h0,  1, 32'h48, 32'h4C);  // fetch_en low, pop drains
    tbl[21] = mk(0, 0, 1, 0, 32'h0,  0, 32'h00, 32'h4C);
    tbl[22] = mk(0, 0, 1, 0, 32'h0,  0, 32'h00, 32'h4C);
    tbl[23] = mk(0, 1, 1, 0, 32'h0,  0, 32'h00, 32'h4C);
    tbl[24] = mk(0, 1, 1, 0, 32'h0,  1, 32'h4C, 32'h50);
    tbl[25] = mk(0, 1, 0, 0, 32'h0,  1, 32'h50, 32'h54);
    tbl[26] = mk(0, 1, 0, 0, 32'h0,  1, 32'h50, 32'h58);  // 3 entries after this edge
    tbl[27] = mk(1, 1, 1, 1, 32'h80, 1, 32'h50, 32'h5C);  // rst beats redirect
    tbl[28] = mk(0, 0, 1, 0, 32'h0,  0, 32'h00, 32'h00);
    tbl[29] = mk(0, 0, 1, 0, 32'h0,  0, 32'h00, 32'h00);

    drive(1, 1, 1, 0, 32'h0);
    repeat (2) @(posedge clk);

    for (int unsigned i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].fe, tbl[i].rdy, tbl[i].redir, tbl[i].rpc);
      #1;
      check_out("d0", i, tbl[i].ev, tbl[i].epc, tbl[i].eaddr, dv0, dpc0, dinst0, addr0);
    end

    // Wrap across 2^32 with a fetch_en gap, on the high RESET_PC instance
    @(negedge clk); drive(1, 1, 1, 0, 32'h0);
    @(negedge clk); drive(0, 1, 1, 0, 32'h0); #1;
    check_out("d1", 100, 0, 32'h0, 32'hFFFF_FFF8, dv1, dpc1, dinst1, addr1);
    @(negedge clk); drive(0, 0, 1, 0, 32'h0); #1;
    check_out("d1", 101, 1, 32'hFFFF_FFF8, 32'hFFFF_FFFC, dv1, dpc1, dinst1, addr1);
    @(negedge clk); #1;
    check_out("d1", 102, 0, 32'h0, 32'hFFFF_FFFC, dv1, dpc1, dinst1, addr1);
    @(negedge clk); #1;
    check_out("d1", 103, 0, 32'h0, 32'hFFFF_FFFC, dv1, dpc1, dinst1, addr1);
    @(negedge clk); drive(0, 1, 1, 0, 32'h0); #1;
    check_out("d1", 104, 0, 32'h0, 32'hFFFF_FFFC, dv1, dpc1, dinst1, addr1);
    @(negedge clk); #1;
    check_out("d1", 105, 1, 32'hFFFF_FFFC, 32'h0000_0000, dv1, dpc1, dinst1, addr1);
    @(negedge clk); #1;
    check_out("d1", 106, 1, 32'h0000_0000, 32'h0000_0004, dv1, dpc1, dinst1, addr1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
